ball_collision_controller: RTL and testbench
============================================

// Module: ball_collision_controller
// PURPOSE
//  Drives the MoveBall control inputs (changeXDirection/changeYDirection) from ball position, direction and
//  paddle positions. Detects paddle hits, wall bounces and misses, keeps the score, runs a serve delay, flags game over.
//  Sits between the paddle controllers, MoveBall and the LT24 display/score logic on the DE1-SoC.
// PARAMETERS
//  X_MAX           239        rightmost ball X (screen 240 wide); reaching it while moving right = right miss
//  Y_MAX           319        bottom wall Y (screen 320 tall); top wall is Y=0
//  LEFT_PADDLE_X   30         left paddle face X; hit window [LEFT_PADDLE_X-HIT_DEPTH+1 .. LEFT_PADDLE_X]
//  RIGHT_PADDLE_X  210        right paddle face X; hit window [RIGHT_PADDLE_X .. RIGHT_PADDLE_X+HIT_DEPTH-1]
//  HIT_DEPTH       4          X window depth, tolerates ball velocity >1
//  PADDLE_LEN      40         paddle span in Y from paddle top: [paddleY .. paddleY+PADDLE_LEN-1]
//  WIN_SCORE       9          score that ends the game (1..15)
//  SERVE_DELAY     50000000   cycles from point scored to serveRequest (1 s @ 50 MHz), >=1
// PORTS
//  clock             in   1  system clock, 50 MHz
//  reset             in   1  asynchronous, active-high
//  ballXValue        in   8  ball X from MoveBall
//  ballYValue        in   9  ball Y from MoveBall
//  direction         in   1  ball X direction from MoveBall, 1 = right
//  leftPaddleY       in   9  left paddle top Y
//  rightPaddleY      in   9  right paddle top Y
//  newGame           in   1  level; restarts the game from GAME_OVER
//  changeXDirection  out  1  one-cycle pulse to MoveBall
//  changeYDirection  out  1  one-cycle pulse to MoveBall
//  serveRequest      out  1  one-cycle pulse: re-centre ball, resume play
//  scoreLeft         out  4  left player score
//  scoreRight        out  4  right player score
//  gameOver          out  1  high while in GAME_OVER
// BEHAVIOUR
//  Reset (async): all outputs 0, state PLAY, both lockouts clear, delay counter 0.
//  All outputs registered; latency 1 clock from input condition to pulse/score update.
//  FSM: PLAY -> POINT on miss; POINT -> PLAY after SERVE_DELAY cycles, with serveRequest on the exit cycle.
//   POINT -> GAME_OVER instead, with no serveRequest, when the updated score == WIN_SCORE.
//   GAME_OVER -> PLAY on newGame=1: scores cleared, serveRequest pulsed the same cycle.
//  PLAY, right side (direction=1): ballX in right hit window and ballY in right paddle span
//   -> changeXDirection. Else if ballX >= X_MAX -> scoreLeft+1 and enter POINT.
//  PLAY, left side (direction=0): mirrored. ballX <= 0 (ballX==0) is a left miss -> scoreRight+1.
//  Hit has priority over miss on the same cycle.
//  X lockout: set with an X pulse, capturing direction. No further X pulse until direction differs from the capture.
//  Wall: ballY==0 or ballY>=Y_MAX -> changeYDirection. Y lockout set with the pulse.
//   Y lockout clears once 0 < ballY < Y_MAX.
//  X and Y pulses may fire on the same cycle (corner); both are required.
//  No direction pulses outside PLAY. Lockouts clear on entering PLAY.
//  Y-span compare is 10-bit (paddleY+PADDLE_LEN cannot wrap). Scores saturate at WIN_SCORE and never wrap.
//  Delay counter width $clog2(SERVE_DELAY+1). It counts only in POINT and is zeroed on POINT entry.
//  newGame is ignored outside GAME_OVER.
// STRUCTURE
//  pong_pkg.vh: state encodings (PLAY/POINT/GAME_OVER) and screen constants (X_MAX, Y_MAX, paddle X defaults),
//   shared with MoveBall and the paddle controllers.
//  One sub-module: paddle_hit_check. Combinational X-window and Y-span compare, instantiated once per paddle.
// TESTING (bench: SERVE_DELAY=5, WIN_SCORE=3)
//  dir=1, X=210, Y=250, rightPaddleY=230 -> changeXDirection high exactly 1 cycle, next cycle.
//   Inputs held 10 cycles -> no repeat. Flip dir, re-enter window -> pulse again.
//  dir=1, X=239, Y=250, rightPaddleY=0 -> scoreLeft 0->1 next cycle, no X pulse.
//   serveRequest pulses 5 cycles later, back in PLAY.
//  Y=0 -> one changeYDirection pulse; Y held 0 for 5 cycles -> none; Y=10 then Y=319 -> second pulse.
//  dir=1, X=211, Y=319, rightPaddleY=290 -> changeXDirection and changeYDirection both high on the same cycle.
//  Three left misses -> scoreRight=3, gameOver=1, no serveRequest, pulses suppressed.
//   newGame=1 -> scores 0, gameOver 0, serveRequest 1 cycle.
//  reset asserted 2 cycles into POINT -> all outputs 0 immediately. No serveRequest after release; state PLAY.

Source files
------------

// File: rtl/ball_collision_controller_pkg.sv
// Shared Pong definitions: game state encoding and screen/paddle geometry defaults.
// MoveBall and the paddle controllers use the same values.
package ball_collision_controller_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_POINT     = 2'd1,
    ST_GAME_OVER = 2'd2
  } game_state_e;

  localparam int X_MAX_DEF          = 239;
  localparam int Y_MAX_DEF          = 319;
  localparam int LEFT_PADDLE_X_DEF  = 30;
  localparam int RIGHT_PADDLE_X_DEF = 210;
  localparam int HIT_DEPTH_DEF      = 4;
  localparam int PADDLE_LEN_DEF     = 40;
  localparam int WIN_SCORE_DEF      = 9;
  localparam int SERVE_DELAY_DEF    = 50000000;

endpackage

// File: rtl/ball_collision_controller_paddle_hit_check.sv
// Combinational paddle contact test: ball X inside the paddle's X window and ball Y
// inside the paddle's vertical span.
module paddle_hit_check #(
  parameter int X_LO       = 27,
  parameter int X_HI       = 30,
  parameter int PADDLE_LEN = 40
) (
  input  logic [7:0] ballX,
  input  logic [8:0] ballY,
  input  logic [8:0] paddleY,
  output logic       hit
);

  logic [9:0] ball_y10;
  logic [9:0] top_y10;
  logic [9:0] end_y10;
  logic       in_x;
  logic       in_y;

  // Widened to 10 bits so paddleY + PADDLE_LEN never wraps.
  assign ball_y10 = {1'b0, ballY};
  assign top_y10  = {1'b0, paddleY};
  assign end_y10  = top_y10 + 10'(PADDLE_LEN);

  assign in_x = (ballX >= 8'(X_LO)) && (ballX <= 8'(X_HI));
  assign in_y = (ball_y10 >= top_y10) && (ball_y10 < end_y10);
  assign hit  = in_x && in_y;

endmodule

// File: rtl/ball_collision_controller.sv
// Pong collision controller: paddle hits, wall bounces, misses, scoring, serve delay
// and game-over, producing registered one-cycle control pulses for MoveBall.
module ball_collision_controller
  import ball_collision_controller_pkg::*;
#(
  parameter int X_MAX          = X_MAX_DEF,
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int LEFT_PADDLE_X  = LEFT_PADDLE_X_DEF,
  parameter int RIGHT_PADDLE_X = RIGHT_PADDLE_X_DEF,
  parameter int HIT_DEPTH      = HIT_DEPTH_DEF,
  parameter int PADDLE_LEN     = PADDLE_LEN_DEF,
  parameter int WIN_SCORE      = WIN_SCORE_DEF,
  parameter int SERVE_DELAY    = SERVE_DELAY_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ballXValue,
  input  logic [8:0] ballYValue,
  input  logic       direction,
  input  logic [8:0] leftPaddleY,
  input  logic [8:0] rightPaddleY,
  input  logic       newGame,
  output logic       changeXDirection,
  output logic       changeYDirection,
  output logic       serveRequest,
  output logic [3:0] scoreLeft,
  output logic [3:0] scoreRight,
  output logic       gameOver
);

  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  game_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic          xlock_q, xlock_d;
  logic          xlock_dir_q, xlock_dir_d;
  logic          ylock_q, ylock_d;
  logic          chg_x_q, chg_x_d;
  logic          chg_y_q, chg_y_d;
  logic          serve_q, serve_d;
  logic          game_over_q, game_over_d;

  logic hit_l, hit_r, hit, x_allow, wall, miss_r, miss_l;

  paddle_hit_check #(
    .X_LO       (LEFT_PADDLE_X - HIT_DEPTH + 1),
    .X_HI       (LEFT_PADDLE_X),
    .PADDLE_LEN (PADDLE_LEN)
  ) u_left_hit (
    .ballX   (ballXValue),
    .ballY   (ballYValue),
    .paddleY (leftPaddleY),
    .hit     (hit_l)
  );

  paddle_hit_check #(
    .X_LO       (RIGHT_PADDLE_X),
    .X_HI       (RIGHT_PADDLE_X + HIT_DEPTH - 1),
    .PADDLE_LEN (PADDLE_LEN)
  ) u_right_hit (
    .ballX   (ballXValue),
    .ballY   (ballYValue),
    .paddleY (rightPaddleY),
    .hit     (hit_r)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  assign hit     = direction ? hit_r : hit_l;
  assign x_allow = !xlock_q || (direction != xlock_dir_q);
  assign wall    = (ballYValue == 9'd0) || (ballYValue >= 9'(Y_MAX));
  assign miss_r  = direction && (ballXValue >= 8'(X_MAX));
  assign miss_l  = !direction && (ballXValue == 8'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    xlock_d     = xlock_q;
    xlock_dir_d = xlock_dir_q;
    ylock_d     = ylock_q;
    chg_x_d     = 1'b0;
    chg_y_d     = 1'b0;
    serve_d     = 1'b0;
    game_over_d = game_over_q;

    unique case (state_q)
      ST_PLAY: begin
        // A paddle contact masks a miss even while the X lockout holds off the pulse.
        if (hit) begin
          if (x_allow) begin
            chg_x_d     = 1'b1;
            xlock_d     = 1'b1;
            xlock_dir_d = direction;
          end
        end else if (miss_r) begin
          score_l_d = sat_inc(score_l_q);
          state_d   = ST_POINT;
          cnt_d     = '0;
        end else if (miss_l) begin
          score_r_d = sat_inc(score_r_q);
          state_d   = ST_POINT;
          cnt_d     = '0;
        end

        if (wall) begin
          if (!ylock_q) begin
            chg_y_d = 1'b1;
            ylock_d = 1'b1;
          end
        end else begin
          ylock_d = 1'b0;
        end
      end

      ST_POINT: begin
        if (cnt_q == CNT_LAST) begin
          if ((score_l_q == WIN) || (score_r_q == WIN)) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_PLAY;
            serve_d = 1'b1;
            xlock_d = 1'b0;
            ylock_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAME_OVER: begin
        if (newGame) begin
          state_d     = ST_PLAY;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_d     = 1'b1;
          game_over_d = 1'b0;
          xlock_d     = 1'b0;
          ylock_d     = 1'b0;
        end
      end

      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      cnt_q       <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      xlock_q     <= 1'b0;
      xlock_dir_q <= 1'b0;
      ylock_q     <= 1'b0;
      chg_x_q     <= 1'b0;
      chg_y_q     <= 1'b0;
      serve_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      xlock_q     <= xlock_d;
      xlock_dir_q <= xlock_dir_d;
      ylock_q     <= ylock_d;
      chg_x_q     <= chg_x_d;
      chg_y_q     <= chg_y_d;
      serve_q     <= serve_d;
      game_over_q <= game_over_d;
    end
  end

  assign changeXDirection = chg_x_q;
  assign changeYDirection = chg_y_q;
  assign serveRequest     = serve_q;
  assign scoreLeft        = score_l_q;
  assign scoreRight       = score_r_q;
  assign gameOver         = game_over_q;

endmodule

// File: tb/tb_ball_collision_controller.sv
// Directed table-driven bench for ball_collision_controller (SERVE_DELAY=5, WIN_SCORE=3).
module tb_ball_collision_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ballXValue;
  logic [8:0] ballYValue;
  logic       direction;
  logic [8:0] leftPaddleY;
  logic [8:0] rightPaddleY;
  logic       newGame;
  logic       changeXDirection;
  logic       changeYDirection;
  logic       serveRequest;
  logic [3:0] scoreLeft;
  logic [3:0] scoreRight;
  logic       gameOver;

  int errors = 0;
  int checks = 0;

  ball_collision_controller #(
    .SERVE_DELAY (5),
    .WIN_SCORE   (3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ballXValue       (ballXValue),
    .ballYValue       (ballYValue),
    .direction        (direction),
    .leftPaddleY      (leftPaddleY),
    .rightPaddleY     (rightPaddleY),
    .newGame          (newGame),
    .changeXDirection (changeXDirection),
    .changeYDirection (changeYDirection),
    .serveRequest     (serveRequest),
    .scoreLeft        (scoreLeft),
    .scoreRight       (scoreRight),
    .gameOver         (gameOver)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       dir;
    logic [7:0] x;
    logic [8:0] y;
    logic [8:0] lp;
    logic [8:0] rp;
    logic       ng;
    int         rep;
    logic       cx;
    logic       cy;
    logic       sv;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dir, input int x, input int y, input int lp, input int rp,
                     input logic ng, input int rep, input logic cx, input logic cy,
                     input logic sv, input int sl, input int sr, input logic go);
    vec_t v;
    v.dir = dir; v.x = 8'(x); v.y = 9'(y); v.lp = 9'(lp); v.rp = 9'(rp); v.ng = ng;
    v.rep = rep; v.cx = cx; v.cy = cy; v.sv = sv; v.sl = 4'(sl); v.sr = 4'(sr); v.go = go;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic cx, input logic cy, input logic sv,
                         input logic [3:0] sl, input logic [3:0] sr, input logic go);
    chk("changeXDirection", row, int'(changeXDirection), int'(cx));
    chk("changeYDirection", row, int'(changeYDirection), int'(cy));
    chk("serveRequest",     row, int'(serveRequest),     int'(sv));
    chk("scoreLeft",        row, int'(scoreLeft),        int'(sl));
    chk("scoreRight",       row, int'(scoreRight),       int'(sr));
    chk("gameOver",         row, int'(gameOver),         int'(go));
  endtask

  task automatic drive(input logic dir, input int x, input int y, input int lp, input int rp,
                       input logic ng);
    direction = dir; ballXValue = 8'(x); ballYValue = 9'(y);
    leftPaddleY = 9'(lp); rightPaddleY = 9'(rp); newGame = ng;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // Idle position: mid-screen, away from walls and paddle windows.
    drive(1'b1, 120, 160, 0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_all(-1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    //  dir  x    y    lp   rp   ng rep cx cy sv sl sr go
    add(1, 120, 160,   0,   0, 1,  1, 0, 0, 0, 0, 0, 0);
    add(1, 210, 250,   0, 230, 0,  1, 1, 0, 0, 0, 0, 0);
    add(1, 210, 250,   0, 230, 0, 10, 0, 0, 0, 0, 0, 0);
    add(0, 120, 160,   0,   0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0,  30, 100,  80,   0, 0,  1, 1, 0, 0, 0, 0, 0);
    add(0,  30, 100,  80,   0, 0,  3, 0, 0, 0, 0, 0, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 120,   0,   0,   0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(1, 120,   0,   0,   0, 0,  5, 0, 0, 0, 0, 0, 0);
    add(1, 120,  10,   0,   0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1, 120, 319,   0,   0, 0,  1, 0, 1, 0, 0, 0, 0);
    add(1, 120, 160,   0,   0, 1,  1, 0, 0, 0, 0, 0, 0);
    add(1, 211, 319,   0, 290, 0,  1, 1, 1, 0, 0, 0, 0);
    add(0, 120, 160,   0,   0, 0,  1, 0, 0, 0, 0, 0, 0);
    // Right miss, serve delay, wall suppressed in POINT
    add(1, 239, 250,   0,   0, 0,  1, 0, 0, 0, 1, 0, 0);
    add(1, 120,   0,   0,   0, 0,  4, 0, 0, 0, 1, 0, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 1, 1, 0, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 0, 1, 0, 0);
    // Three left misses end the game
    add(0,   0, 160, 200,   0, 0,  1, 0, 0, 0, 1, 1, 0);
    add(1, 120, 160,   0,   0, 0,  4, 0, 0, 0, 1, 1, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 1, 1, 1, 0);
    add(0,   0, 160, 200,   0, 0,  1, 0, 0, 0, 1, 2, 0);
    add(1, 120, 160,   0,   0, 0,  4, 0, 0, 0, 1, 2, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 1, 1, 2, 0);
    add(0,   0, 160, 200,   0, 0,  1, 0, 0, 0, 1, 3, 0);
    add(1, 120, 160,   0,   0, 0,  4, 0, 0, 0, 1, 3, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 0, 1, 3, 1);
    add(1, 210, 250,   0, 230, 0,  3, 0, 0, 0, 1, 3, 1);
    add(1, 120,   0,   0,   0, 0,  1, 0, 0, 0, 1, 3, 1);
    add(1, 120, 160,   0,   0, 1,  1, 0, 0, 1, 0, 0, 0);
    add(1, 120, 160,   0,   0, 0,  1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].dir, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].lp), int'(tbl[i].rp),
            tbl[i].ng);
      for (int r = 0; r < tbl[i].rep; r++) begin
        step();
        chk_all(i, tbl[i].cx, tbl[i].cy, tbl[i].sv, tbl[i].sl, tbl[i].sr, tbl[i].go);
      end
    end

    // Reset asserted two cycles into POINT clears outputs without a clock edge
    drive(1'b1, 239, 160, 0, 0, 1'b0);
    step();
    chk_all(100, 0, 0, 0, 1, 0, 0);
    drive(1'b1, 120, 160, 0, 0, 1'b0);
    step();
    step();
    chk_all(101, 0, 0, 0, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_all(102, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all(103 + k, 0, 0, 0, 0, 0, 0);
    end
    drive(1'b1, 210, 250, 0, 230, 1'b0);
    step();
    chk_all(120, 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
